riscv_hazard_unit: RTL

Parametrised forwarding and hazard unit for the RISC-V core. It replaces the purely combinational EX/WB forward selects with an internal destination-tag pipeline covering NUM_STAGES post-ID stages. It adds youngest-match priority, load-use stall generation, store-data forwarding, flush handling and a saturating stall counter. It sits beside the ID stage and drives the ID/EX operand muxes and the pipeline stall line.

---
 rtl/riscv_hazard_pkg.sv | 24 ++
 rtl/riscv_hazard_unit_match.sv | 32 +++
 rtl/riscv_hazard_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/riscv_hazard_pkg.sv
// Shared types and helpers for the forwarding/hazard unit.
package riscv_hazard_pkg;

  localparam int unsigned FWD_RF = 0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } tag_entry_t;

  localparam int unsigned TAG_W = $bits(tag_entry_t);

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/riscv_hazard_unit_match.sv
// Per-source priority encoder: picks the youngest tag entry that writes the source register.
module hazard_src_match
  import riscv_hazard_pkg::*;
#(
  parameter int unsigned NUM_STAGES       = 2,
  parameter int unsigned LOAD_READY_STAGE = 2,
  parameter int unsigned FWD_W            = 2
) (
  input  logic [NUM_STAGES*TAG_W-1:0] entries,
  input  logic [4:0]                  addr,
  input  logic                        used,
  output logic [FWD_W-1:0]            sel,
  output logic                        needs_stall
);

  tag_entry_t [NUM_STAGES-1:0] tags;
  assign tags = entries;

  always_comb begin
    sel         = FWD_W'(FWD_RF);
    needs_stall = 1'b0;
    // Walk oldest to youngest so the youngest match is written last.
    for (int k = int'(NUM_STAGES); k >= 1; k--) begin
      if (used && tags[k-1].valid && tags[k-1].we && (tags[k-1].rd != 5'd0) &&
          (tags[k-1].rd == addr)) begin
        sel         = FWD_W'(k);
        needs_stall = tags[k-1].is_load && (k < int'(LOAD_READY_STAGE));
      end
    end
  end

endmodule

// File: rtl/riscv_hazard_unit.sv
// Forwarding and hazard unit: tracks destination tags of post-ID stages and
// drives operand forward selects, load-use stalls and a saturating stall counter.
module riscv_hazard_unit
  import riscv_hazard_pkg::*;
#(
  parameter int unsigned NUM_STAGES       = 2,
  parameter int unsigned LOAD_READY_STAGE = 2,
  parameter int unsigned CNT_WIDTH        = 32,
  localparam int unsigned FWD_W           = clog2(NUM_STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [4:0]           id_rs1_addr,
  input  logic [4:0]           id_rs2_addr,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic                 id_is_store,
  input  logic [4:0]           id_rd_addr,
  input  logic                 id_reg_we,
  input  logic                 id_is_load,
  input  logic                 pipe_advance,
  input  logic                 flush,
  output logic                 hazard_stall,
  output logic [FWD_W-1:0]     fwd_a_sel,
  output logic [FWD_W-1:0]     fwd_b_sel,
  output logic [FWD_W-1:0]     fwd_store_sel,
  output logic [CNT_WIDTH-1:0] stall_count
);

  tag_entry_t [NUM_STAGES-1:0] entries_q, entries_d;
  logic [CNT_WIDTH-1:0]        stall_count_q, stall_count_d;
  logic                        stall_a, stall_b, stall_st;

  hazard_src_match #(
    .NUM_STAGES       (NUM_STAGES),
    .LOAD_READY_STAGE (LOAD_READY_STAGE),
    .FWD_W            (FWD_W)
  ) u_match_a (
    .entries     (entries_q),
    .addr        (id_rs1_addr),
    .used        (id_rs1_used),
    .sel         (fwd_a_sel),
    .needs_stall (stall_a)
  );

  // rs2 feeds either the ALU or the store-data path, never both.
  hazard_src_match #(
    .NUM_STAGES       (NUM_STAGES),
    .LOAD_READY_STAGE (LOAD_READY_STAGE),
    .FWD_W            (FWD_W)
  ) u_match_b (
    .entries     (entries_q),
    .addr        (id_rs2_addr),
    .used        (id_rs2_used & ~id_is_store),
    .sel         (fwd_b_sel),
    .needs_stall (stall_b)
  );

  hazard_src_match #(
    .NUM_STAGES       (NUM_STAGES),
    .LOAD_READY_STAGE (LOAD_READY_STAGE),
    .FWD_W            (FWD_W)
  ) u_match_st (
    .entries     (entries_q),
    .addr        (id_rs2_addr),
    .used        (id_rs2_used & id_is_store),
    .sel         (fwd_store_sel),
    .needs_stall (stall_st)
  );

  assign hazard_stall = id_valid & ~flush & (stall_a | stall_b | stall_st);
  assign stall_count  = stall_count_q;

  always_comb begin
    entries_d     = entries_q;
    stall_count_d = stall_count_q;
    if (pipe_advance) begin
      for (int k = int'(NUM_STAGES) - 1; k >= 1; k--) begin
        entries_d[k] = entries_q[k-1];
      end
      entries_d[0] = '0;
      if (id_valid && !hazard_stall && !flush) begin
        entries_d[0] = '{valid: 1'b1, rd: id_rd_addr, we: id_reg_we, is_load: id_is_load};
      end
      if (hazard_stall && (stall_count_q != '1)) begin
        stall_count_d = stall_count_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q     <= '0;
      stall_count_q <= '0;
    end else begin
      entries_q     <= entries_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule
